// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the row convolution engine.
// Holds the FSM state enum, accumulator width calculation and saturation.
package conv_pkg;

  typedef enum logic [1:0] {
    FILL,
    COMPUTE,
    OUTPUT
  } state_t;

  // Accumulator wide enough for CH*F*F full-scale products.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Clamp v to the signed range of a dw-bit value.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output column: serial multiply-accumulate over all taps, then
// shift + saturate into a held result.
// Ports: clk, reset (sync, high); clear zeroes the accumulator; en adds
// pixel*weight; latch captures the saturated result; result is the output.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic                         latch,
  input  logic signed [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [ACC_W-1:0]        acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [63:0]             wide;

  assign prod = pixel * weight;
  assign wide = 64'(acc) >>> SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear) acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
      if (latch) result <= DATA_WIDTH'(saturate(wide, DATA_WIDTH));
    end
  end

endmodule

// File: rtl/conv_row_engine.sv
// Streaming row convolution: buffers F rows (stride 1), then runs one tap
// per cycle across all W-F+1 output columns in parallel.
// Ports: row_valid/row_ready/row_data/row_last input row stream; filter
// weights captured per window; out_valid/out_ready/out_data/out_last result.
module conv_row_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int W          = 6,
  parameter int F          = 3,
  parameter int CH         = 1,
  parameter int SHIFT      = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [0:CH*W*DATA_WIDTH-1]       row_data,
  input  logic                             row_last,
  input  logic [0:CH*F*F*DATA_WIDTH-1]     filter,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [0:(W-F+1)*DATA_WIDTH-1]    out_data,
  output logic                             out_last
);

  localparam int NOUT  = W - F + 1;
  localparam int NTAP  = CH * F * F;
  localparam int ACC_W = acc_width(DATA_WIDTH, NTAP);
  localparam int RW    = CH * W * DATA_WIDTH;
  localparam int RH_W  = $clog2(F + 1);
  localparam int T_W   = $clog2(NTAP + 1);
  localparam int C_W   = $clog2(CH + 1);

  if (W < F || F < 1 || CH < 1) begin : g_bad_params
    $fatal(1, "conv_row_engine: need W >= F >= 1 and CH >= 1");
  end

  state_t state;
  state_t next;

  logic [0:RW-1]                 win [F];
  logic [0:NTAP*DATA_WIDTH-1]    filt;
  logic [RH_W-1:0]               rows_held;
  logic [T_W-1:0]                tap;
  logic [RH_W-1:0]               k_idx;
  logic [RH_W-1:0]               r_idx;
  logic [C_W-1:0]                c_idx;
  logic                          win_last;
  logic                          last_q;

  logic                          accept;
  logic                          full;
  logic                          mac_en;
  logic                          mac_latch;
  logic [0:RW-1]                 cur_row;
  logic signed [DATA_WIDTH-1:0]  weight;

  assign accept    = row_valid && row_ready;
  assign full      = (32'(rows_held) + 1 == F);
  assign mac_en    = (state == COMPUTE) && (32'(tap) != NTAP);
  // Extra cycle after the last tap registers the saturated result.
  assign mac_latch = (state == COMPUTE) && (32'(tap) == NTAP);
  assign cur_row   = win[r_idx];
  assign weight    = filt[32'(tap) * DATA_WIDTH +: DATA_WIDTH];
  assign out_last  = last_q;

  always_comb begin
    next      = state;
    row_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      FILL: begin
        row_ready = !reset;
        if (accept && full) next = COMPUTE;
      end
      COMPUTE: begin
        if (mac_latch) next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) next = FILL;
      end
      default: next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      rows_held <= '0;
      tap       <= '0;
      k_idx     <= '0;
      r_idx     <= '0;
      c_idx     <= '0;
      filt      <= '0;
      win_last  <= 1'b0;
      last_q    <= 1'b0;
      for (int i = 0; i < F; i++) win[i] <= '0;
    end else begin
      state <= next;
      if (accept) begin
        for (int i = 0; i < F - 1; i++) win[i] <= win[i + 1];
        win[F-1] <= row_data;
        if (full) begin
          filt     <= filter;
          win_last <= row_last;
          tap      <= '0;
          k_idx    <= '0;
          r_idx    <= '0;
          c_idx    <= '0;
        end else if (row_last) begin
          rows_held <= '0;
        end else begin
          rows_held <= rows_held + 1'b1;
        end
      end
      // Tap order k fastest, then r, then c matches t = (c*F + r)*F + k.
      if (mac_en) begin
        tap <= tap + 1'b1;
        if (32'(k_idx) == F - 1) begin
          k_idx <= '0;
          if (32'(r_idx) == F - 1) begin
            r_idx <= '0;
            c_idx <= c_idx + 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end else begin
          k_idx <= k_idx + 1'b1;
        end
      end
      if (mac_latch) last_q <= win_last;
      if (state == OUTPUT && out_ready) begin
        last_q    <= 1'b0;
        rows_held <= win_last ? '0 : RH_W'(F - 1);
      end
    end
  end

  for (genvar n = 0; n < NOUT; n++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] pixel;
    logic signed [DATA_WIDTH-1:0] result;

    assign pixel =
      cur_row[(32'(c_idx) * W + n + 32'(k_idx)) * DATA_WIDTH +: DATA_WIDTH];
    assign out_data[n*DATA_WIDTH +: DATA_WIDTH] = result;

    conv_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_W     (ACC_W),
      .SHIFT     (SHIFT)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (accept && full),
      .en    (mac_en),
      .latch (mac_latch),
      .pixel (pixel),
      .weight(weight),
      .result(result)
    );
  end

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed self-checking bench for conv_row_engine.
// Two instances: CH=1 for most scenarios, CH=2 for the reset/latency case.
module tb_conv_row_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        row_valid, row_ready, row_last;
  logic [0:47] row_data;
  logic [0:71] filter;
  logic        out_valid, out_ready, out_last;
  logic [0:31] out_data;

  logic         row_valid2, row_ready2, row_last2;
  logic [0:95]  row_data2;
  logic [0:143] filter2;
  logic         out_valid2, out_ready2, out_last2;
  logic [0:31]  out_data2;

  int passed = 0;
  int total  = 0;

  conv_row_engine #(
    .DATA_WIDTH(8), .W(6), .F(3), .CH(1), .SHIFT(0)
  ) dut (
    .clk(clk), .reset(reset),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_last(row_last),
    .filter(filter),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  conv_row_engine #(
    .DATA_WIDTH(8), .W(6), .F(3), .CH(2), .SHIFT(0)
  ) dut2 (
    .clk(clk), .reset(reset),
    .row_valid(row_valid2), .row_ready(row_ready2),
    .row_data(row_data2), .row_last(row_last2),
    .filter(filter2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_last(out_last2)
  );

  function automatic logic [0:47] rep_row(input logic [7:0] v);
    logic [0:47] r;
    for (int j = 0; j < 6; j++) r[j*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [0:71] rep_filt(input logic [7:0] v);
    logic [0:71] f;
    for (int t = 0; t < 9; t++) f[t*8 +: 8] = v;
    return f;
  endfunction

  task automatic send_row(input logic [0:47] d, input logic last);
    int n = 0;
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = d;
    row_last  = last;
    while (!row_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    row_last  = 1'b0;
    total++;
    if (n >= 100) $display("FAIL accept_timeout waited %0d cycles", n);
    else passed++;
  endtask

  task automatic send_row2(input logic [0:95] d, input logic last);
    int n = 0;
    @(negedge clk);
    row_valid2 = 1'b1;
    row_data2  = d;
    row_last2  = last;
    while (!row_ready2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    row_valid2 = 1'b0;
    row_last2  = 1'b0;
    total++;
    if (n >= 100) $display("FAIL accept2_timeout waited %0d cycles", n);
    else passed++;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_out2(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid2) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (row_ready !== 1'b0) $display("FAIL rst_row_ready got %b want 0", row_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (out_data !== 32'h0) $display("FAIL rst_out_data got %h want 0", out_data);
    else passed++;
    total++;
    if (out_last !== 1'b0) $display("FAIL rst_out_last got %b want 0", out_last);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (row_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", row_ready);
    else passed++;
    total++;
    if (row_ready2 !== 1'b1) $display("FAIL post_rst_ready2 got %b want 1", row_ready2);
    else passed++;
  endtask

  task automatic test_ones();
    int lat;
    filter = rep_filt(8'd1);
    send_row(rep_row(8'd1), 1'b0);
    send_row(rep_row(8'd1), 1'b0);
    send_row(rep_row(8'd1), 1'b1);
    filter = rep_filt(8'd0);
    wait_out(lat);
    total++;
    if (lat !== 10) $display("FAIL ones_latency got %0d want 10", lat);
    else passed++;
    total++;
    if (out_data !== 32'h09090909) $display("FAIL ones_data got %h want 09090909", out_data);
    else passed++;
    total++;
    if (out_last !== 1'b1) $display("FAIL ones_last got %b want 1", out_last);
    else passed++;
    take_out();
  endtask

  task automatic test_frame();
    int lat;
    logic [7:0] e;
    logic [31:0] exp_d;
    filter = rep_filt(8'd1);
    send_row(rep_row(8'd1), 1'b0);
    send_row(rep_row(8'd2), 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_row(rep_row(8'(i + 3)), (i == 3));
      wait_out(lat);
      e = 8'(9 * (i + 2));
      exp_d = {4{e}};
      total++;
      if (out_data !== exp_d) $display("FAIL frame_data%0d got %h want %h", i, out_data, exp_d);
      else passed++;
      total++;
      if (out_last !== (i == 3)) $display("FAIL frame_last%0d got %b want %b", i, out_last, (i == 3));
      else passed++;
      take_out();
    end
  endtask

  task automatic test_saturation();
    int lat;
    filter = rep_filt(8'd127);
    for (int i = 0; i < 3; i++) send_row(rep_row(8'd127), (i == 2));
    wait_out(lat);
    total++;
    if (out_data !== 32'h7F7F7F7F) $display("FAIL sat_pos got %h want 7f7f7f7f", out_data);
    else passed++;
    take_out();
    filter = rep_filt(8'h80);
    for (int i = 0; i < 3; i++) send_row(rep_row(8'd127), (i == 2));
    wait_out(lat);
    total++;
    if (out_data !== 32'h80808080) $display("FAIL sat_neg got %h want 80808080", out_data);
    else passed++;
    take_out();
  endtask

  task automatic test_ramp();
    int lat;
    logic [0:47] r;
    logic [0:71] f;
    for (int j = 0; j < 6; j++) r[j*8 +: 8] = 8'(j + 1);
    for (int t = 0; t < 9; t++) f[t*8 +: 8] = 8'(t + 1);
    filter = f;
    send_row(r, 1'b0);
    send_row(rep_row(8'd0), 1'b0);
    send_row(rep_row(8'd0), 1'b1);
    wait_out(lat);
    total++;
    if (out_data !== 32'h0E141A20) $display("FAIL ramp_data got %h want 0e141a20", out_data);
    else passed++;
    take_out();
  endtask

  task automatic test_backpressure();
    int lat;
    filter = rep_filt(8'd1);
    for (int i = 0; i < 3; i++) send_row(rep_row(8'd2), (i == 2));
    wait_out(lat);
    row_valid = 1'b1;
    row_data  = rep_row(8'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_data !== 32'h12121212) $display("FAIL bp_data%0d got %h want 12121212", i, out_data);
      else passed++;
      total++;
      if (row_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold%0d got ready=%b valid=%b want ready=0 valid=1", i, row_ready, out_valid);
      else passed++;
    end
    row_valid = 1'b0;
    take_out();
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (row_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", row_ready);
    else passed++;
  endtask

  task automatic test_short_frame();
    int lat;
    logic seen = 1'b0;
    filter = rep_filt(8'd1);
    send_row(rep_row(8'd7), 1'b0);
    send_row(rep_row(8'd7), 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL short_no_output got %b want 0", seen);
    else passed++;
    send_row(rep_row(8'd1), 1'b0);
    send_row(rep_row(8'd2), 1'b0);
    send_row(rep_row(8'd3), 1'b1);
    wait_out(lat);
    total++;
    if (lat !== 10) $display("FAIL short_next_latency got %0d want 10", lat);
    else passed++;
    total++;
    if (out_data !== 32'h12121212) $display("FAIL short_next_data got %h want 12121212", out_data);
    else passed++;
    take_out();
  endtask

  task automatic test_reset_mid_compute();
    int lat;
    logic seen = 1'b0;
    logic [0:95] r2;
    logic [0:143] f2;
    for (int j = 0; j < 6; j++) begin
      r2[j*8 +: 8]      = 8'd1;
      r2[48 + j*8 +: 8] = 8'd2;
    end
    for (int t = 0; t < 18; t++) f2[t*8 +: 8] = (t < 9) ? 8'd1 : 8'd2;
    filter2 = f2;
    for (int i = 0; i < 3; i++) send_row2(r2, (i == 2));
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid2) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL midrst_no_output got %b want 0", seen);
    else passed++;
    for (int i = 0; i < 3; i++) send_row2(r2, (i == 2));
    wait_out2(lat);
    total++;
    if (lat !== 19) $display("FAIL ch2_latency got %0d want 19", lat);
    else passed++;
    total++;
    if (out_data2 !== 32'h2D2D2D2D) $display("FAIL ch2_data got %h want 2d2d2d2d", out_data2);
    else passed++;
    total++;
    if (out_last2 !== 1'b1) $display("FAIL ch2_last got %b want 1", out_last2);
    else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    row_valid  = 1'b0;
    row_last   = 1'b0;
    row_data   = '0;
    filter     = '0;
    out_ready  = 1'b0;
    row_valid2 = 1'b0;
    row_last2  = 1'b0;
    row_data2  = '0;
    filter2    = '0;
    out_ready2 = 1'b0;
    test_reset();
    test_ones();
    test_frame();
    test_saturation();
    test_ramp();
    test_backpressure();
    test_short_frame();
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_row_engine.md
CONV_ROW_ENGINE -- requirements
Module: conv_row_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8: signed pixel/weight/output width.
- W, 6: row width in pixels.
- F, 3: kernel size.
- CH, 1: input channel count.
- SHIFT, 0: arithmetic right shift applied before saturation.
REQ-002 Ports (name, direction, width, meaning), one per line; clk and reset first:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- row_valid, in, 1: input row offered.
- row_ready, out, 1: engine accepts a row.
- row_data, in, CH*W*DATA_WIDTH: one image row, all channels.
- row_last, in, 1: last row of frame, qualified by row_valid.
- filter, in, CH*F*F*DATA_WIDTH: kernel weights.
- out_valid, out, 1: output row held.
- out_ready, in, 1: consumer accepts the output row.
- out_data, out, (W-F+1)*DATA_WIDTH: convolved row.
- out_last, out, 1: out_data is the last output row of the frame.
REQ-003 One clock domain; reset is synchronous and active-high on port reset.
REQ-004 All vectors are ascending [0:N-1]. Element 0 occupies the most-significant slice. Channel c of row_data is slice [c*W*DW +: W*DW]; column j within a channel is at offset j*DW.

Function
REQ-005 Arithmetic is two's complement signed. Accumulator width ACC_W = 2*DATA_WIDTH + clog2(CH*F*F). There is no overflow inside the accumulator.
REQ-006 Each output = sat(acc >>> SHIFT), clamped to [-2^(DW-1), 2^(DW-1)-1].
REQ-007 Tap index t = (c*F + r)*F + k. Output column n accumulates window[r].ch[c].col[n+k] * filter[t]. Window row 0 is the oldest row.
REQ-008 FSM states:
- FILL: row_ready=1; holds a rows_held counter.
- COMPUTE: row_ready=0, out_valid=0.
- OUTPUT: out_valid=1, row_ready=0.
REQ-009 FILL transitions (row accepted when row_valid && row_ready):
- Accepted row is shifted into the window buffer.
- If rows_held+1 == F: go to COMPUTE and capture filter into an internal register.
- Otherwise: increment rows_held.
REQ-010 COMPUTE lasts exactly CH*F*F cycles, one tap per cycle, all W-F+1 columns processed in parallel. Changes to filter during COMPUTE have no effect.
REQ-011 out_valid rises exactly CH*F*F+1 cycles after the accepting edge.
REQ-012 In OUTPUT, out_data and out_last remain stable while out_valid && !out_ready.
REQ-013 On the out_valid && out_ready handshake, return to FILL:
- If the window's newest row carried row_last: rows_held=0.
- Otherwise: rows_held=F-1, giving a sliding window of stride 1.
REQ-014 out_last is 1 exactly for the output row computed from a window whose newest row carried row_last.
REQ-015 A row_last accepted while rows_held+1 < F (short frame) discards the partial window and sets rows_held=0. No output row is produced.
REQ-016 No input row is accepted in COMPUTE or OUTPUT; rows offered then wait under row_valid.
REQ-017 Parameters must satisfy W>=F>=1 and CH>=1; elaboration is fatal otherwise.

Reset
REQ-018 While reset=1 at a clock edge:
- state <= FILL and rows_held <= 0.
- Accumulators, window and filter registers <= 0.
- out_valid=0, out_data=0, out_last=0.
REQ-019 row_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
REQ-020 Reset asserted in COMPUTE or OUTPUT discards all partial and pending results. No out_valid pulse follows.

Structure
REQ-021 Package conv_pkg holds the FSM state enum, the ACC_W calculation function and the saturation function.
REQ-022 Per-column multiply-accumulate is sub-module conv_mac_lane, instantiated W-F+1 times. The top level holds the FSM, window buffer and tap counter.

Verification (DW=8, W=6, F=3, CH=1 unless stated)
REQ-023 Three all-ones rows with an all-ones filter -> out_data = four lanes of 9; out_valid 10 cycles after the third accept.
REQ-024 Six rows with row i = all i+1, row_last on row 6, all-ones filter:
- Output rows are 18, 27, 36, 45 (each lane).
- out_last=1 only on the fourth output row.
REQ-025 Saturation:
- All inputs 127 with all-127 filter -> every lane 0x7F.
- All inputs 127 with all -128 filter -> every lane 0x80.
REQ-026 Backpressure: out_ready held low 5 cycles -> out_data stable, row_ready=0, no row accepted. Release -> one handshake, then FILL.
REQ-027 Short frame of 2 rows with row_last on row 2 -> no output. The following 3 rows produce a normal output row.
REQ-028 Reset mid-COMPUTE -> out_valid stays 0. The next frame is correct, with CH=2 and F=3 giving latency 19.
